// File: rtl/sseg_mux_driver.sv
// Time-multiplexed seven-segment driver: hex decode, blanking, leading-zero
// suppression, frame-synchronous updates, anti-ghost guard. Optional PWM dimming under SSEG_DIMMING_EN.
module sseg_mux_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIV_W       = 16,
    parameter int GUARD_CYC   = 4,
    parameter int AN_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    input  logic                    load,
`ifdef SSEG_DIMMING_EN
    input  logic [3:0]              brightness,
`endif
    output logic [6:0]              sseg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0]      GUARD_V  = DIV_W'(GUARD_CYC);
    localparam logic [6:0]            SEG_XOR  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_XOR   = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_XOR   = (AN_ACT_LOW != 0) ? '1 : '0;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
        endcase
    endfunction

    logic [DIV_W-1:0]        prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] stage_data_q, stage_data_d, shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   stage_blank_q, stage_blank_d, shadow_blank_q, shadow_blank_d;
    logic [6:0]              sseg_q, sseg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    boundary, wrap;
    logic [3:0]              nib;
    logic                    dp_bit, blank_bit, upper_nz, dark, lit;
    logic [6:0]              seg_on;
    logic [NUM_DIGITS-1:0]   an_on;

    // Scan timing and tear-free data staging
    always_comb begin
        boundary       = &prescaler_q;
        wrap           = boundary && (idx_q == LAST_IDX);
        prescaler_d    = prescaler_q + DIV_W'(1);
        idx_d          = idx_q;
        pending_d      = pending_q;
        stage_data_d   = stage_data_q;
        stage_dp_d     = stage_dp_q;
        stage_blank_d  = stage_blank_q;
        shadow_data_d  = shadow_data_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        if (boundary) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        if (load) begin
            stage_data_d  = data;
            stage_dp_d    = dp_in;
            stage_blank_d = blank;
            pending_d     = 1'b1;
        end
        if (wrap) begin
            pending_d = 1'b0;
            // A load landing on the wrap edge bypasses staging so it shows this frame.
            if (load) begin
                shadow_data_d  = data;
                shadow_dp_d    = dp_in;
                shadow_blank_d = blank;
            end else if (pending_q) begin
                shadow_data_d  = stage_data_q;
                shadow_dp_d    = stage_dp_q;
                shadow_blank_d = stage_blank_q;
            end
        end
    end

    // Digit selection, suppression and pin polarity
    always_comb begin
        nib       = 4'h0;
        dp_bit    = 1'b0;
        blank_bit = 1'b0;
        upper_nz  = 1'b0;
        an_on     = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == idx_q) begin
                nib       = shadow_data_q[4*j +: 4];
                dp_bit    = shadow_dp_q[j];
                blank_bit = shadow_blank_q[j];
            end
            if ((IDX_W'(j) >= idx_q) && (shadow_data_q[4*j +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        dark = blank_bit | (lz_en & (idx_q != '0) & ~upper_nz);
        lit  = ~dark & (prescaler_q >= GUARD_V);
`ifdef SSEG_DIMMING_EN
        lit  = lit & (prescaler_q[DIV_W-1 -: 4] <= brightness);
`endif
        for (int j = 0; j < NUM_DIGITS; j++) begin
            an_on[j] = lit && (IDX_W'(j) == idx_q);
        end
        seg_on       = dark ? 7'h00 : hex_font(nib);
        sseg_d       = seg_on ^ SEG_XOR;
        dp_d         = (~dark & dp_bit) ^ DP_XOR;
        an_d         = an_on ^ AN_XOR;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler_q    <= '0;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            stage_data_q   <= '0;
            stage_dp_q     <= '0;
            stage_blank_q  <= '0;
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            sseg_q         <= SEG_XOR;
            dp_q           <= DP_XOR;
            an_q           <= AN_XOR;
            frame_done_q   <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            stage_data_q   <= stage_data_d;
            stage_dp_q     <= stage_dp_d;
            stage_blank_q  <= stage_blank_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            sseg_q         <= sseg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign sseg       = sseg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Bench for sseg_mux_driver: a 4-digit and a 3-digit instance (DIV_W=4, GUARD_CYC=2)
// checked against a time-based reference model plus directed vectors.
module tb_sseg_mux_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
`ifdef SSEG_DIMMING_EN
    logic [3:0]  brightness = 4'hF;
`endif
    logic [6:0]  sseg, sseg3;
    logic        dp, dp3, frame_done, frame_done3;
    logic [3:0]  an;
    logic [2:0]  an3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sseg_mux_driver #(.NUM_DIGITS(4), .DIV_W(4), .GUARD_CYC(2)) dut4 (
        .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .blank(blank),
        .lz_en(lz_en), .load(load),
`ifdef SSEG_DIMMING_EN
        .brightness(brightness),
`endif
        .sseg(sseg), .dp(dp), .an(an), .frame_done(frame_done));

    sseg_mux_driver #(.NUM_DIGITS(3), .DIV_W(4), .GUARD_CYC(2)) dut3 (
        .clk(clk), .reset(reset), .data(data[11:0]), .dp_in(dp_in[2:0]), .blank(blank[2:0]),
        .lz_en(lz_en), .load(load),
`ifdef SSEG_DIMMING_EN
        .brightness(brightness),
`endif
        .sseg(sseg3), .dp(dp3), .an(an3), .frame_done(frame_done3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int          t;
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  b;
    } ev_t;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] sseg;
        logic       dp;
        logic       fd;
    } exp_t;

    ev_t  evq[$];
    int   mt = 0;
    bit   mvalid = 0;
    exp_t e4, e3;

    // Expected pins after the clock edge at which the count since reset release is t.
    function automatic exp_t model(input int n, input int t, input logic lz);
        exp_t        e;
        int          pre, slot, idx, frame, dm, nb, a;
        logic [15:0] d;
        logic [3:0]  p, b;
        bit          dark, lit;
        pre   = t % 16;
        slot  = t / 16;
        idx   = slot % n;
        frame = slot / n;
        d = '0; p = '0; b = '0;
        foreach (evq[i]) begin
            if (evq[i].t <= frame * 16 * n - 1) begin
                d = evq[i].d; p = evq[i].p; b = evq[i].b;
            end
        end
        dm   = int'(d) & ((1 << (4 * n)) - 1);
        nb   = (dm >> (4 * idx)) & 15;
        dark = b[idx] || (lz && idx != 0 && (dm >> (4 * idx)) == 0);
        lit  = !dark && pre >= 2;
`ifdef SSEG_DIMMING_EN
        if (pre > int'(brightness)) lit = 0;
`endif
        a = (1 << n) - 1;
        if (lit) a = a & ~(1 << idx);
        e.an   = a[7:0];
        e.sseg = dark ? 7'h7F : ~FONT[nb];
        e.dp   = dark ? 1'b1 : ~p[idx];
        e.fd   = (t % (16 * n)) == (16 * n - 1);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            evq.delete();
            mt     = 0;
            mvalid = 1;
            e4 = '{an: 8'hFF, sseg: 7'h7F, dp: 1'b1, fd: 1'b0};
            e3 = e4;
        end else if (mvalid) begin
            ev_t ev;
            e4 = model(4, mt, lz_en);
            e3 = model(3, mt, lz_en);
            if (load) begin
                ev.t = mt; ev.d = data; ev.p = dp_in; ev.b = blank;
                evq.push_back(ev);
            end
            mt++;
        end
        if (mvalid) begin
            #1;
            chk("m_an4", an, e4.an[3:0]);
            chk("m_sseg4", sseg, e4.sseg);
            chk("m_dp4", dp, e4.dp);
            chk("m_fd4", frame_done, e4.fd);
            chk("m_an3", an3, e3.an[2:0]);
            chk("m_sseg3", sseg3, e3.sseg);
            chk("m_dp3", dp3, e3.dp);
            chk("m_fd3", frame_done3, e3.fd);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset(input bit check);
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (check) begin
            chk("rst_an", an, 4'hF);
            chk("rst_sseg", sseg, 7'h7F);
            chk("rst_dp", dp, 1'b1);
            chk("rst_fd", frame_done, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Return at the negedge following the edge whose count is T.
    task automatic goto(input int T);
        int n = 0;
        while (mt < T + 1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (mt != T + 1) begin
            total++;
            bad++;
            $display("FAIL goto_timing got=%0d want=%0d", mt, T + 1);
        end
    endtask

    task automatic load_now(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data = d; dp_in = p; blank = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  b;
        logic        lz;
        int          idx;
        logic [6:0]  s;
        logic [3:0]  a;
        logic        dpo;
    } vec_t;

    vec_t vt[15];

    initial begin
        vt[0]  = '{16'h12AF, 4'b0100, 4'h0, 1'b0, 0, 7'h0E, 4'b1110, 1'b1};
        vt[1]  = '{16'h12AF, 4'b0100, 4'h0, 1'b0, 1, 7'h08, 4'b1101, 1'b1};
        vt[2]  = '{16'h12AF, 4'b0100, 4'h0, 1'b0, 2, 7'h24, 4'b1011, 1'b0};
        vt[3]  = '{16'h12AF, 4'b0100, 4'h0, 1'b0, 3, 7'h79, 4'b0111, 1'b1};
        vt[4]  = '{16'h0030, 4'h0,    4'h0, 1'b1, 3, 7'h7F, 4'b1111, 1'b1};
        vt[5]  = '{16'h0030, 4'h0,    4'h0, 1'b1, 2, 7'h7F, 4'b1111, 1'b1};
        vt[6]  = '{16'h0030, 4'h0,    4'h0, 1'b1, 1, 7'h30, 4'b1101, 1'b1};
        vt[7]  = '{16'h0030, 4'h0,    4'h0, 1'b1, 0, 7'h40, 4'b1110, 1'b1};
        vt[8]  = '{16'h0000, 4'h0,    4'h0, 1'b1, 0, 7'h40, 4'b1110, 1'b1};
        vt[9]  = '{16'h0000, 4'h0,    4'h0, 1'b1, 1, 7'h7F, 4'b1111, 1'b1};
        vt[10] = '{16'h1234, 4'h1,    4'h1, 1'b0, 0, 7'h7F, 4'b1111, 1'b1};
        vt[11] = '{16'h1234, 4'b1000, 4'h0, 1'b0, 3, 7'h79, 4'b0111, 1'b0};
        vt[12] = '{16'h0030, 4'h0,    4'h0, 1'b0, 3, 7'h40, 4'b0111, 1'b1};
        vt[13] = '{16'h0102, 4'h0,    4'h0, 1'b1, 1, 7'h40, 4'b1101, 1'b1};
        vt[14] = '{16'hBCDE, 4'h0,    4'h0, 1'b1, 2, 7'h46, 4'b1011, 1'b1};

        // Reset values and scan timing
        do_reset(1'b1);
        goto(1);  chk("an_guard0", an, 4'hF);
        goto(2);  chk("an_slot0", an, 4'b1110);
        goto(16); chk("an_guard1", an, 4'hF);
        goto(18); chk("an_slot1", an, 4'b1101);
        goto(34); chk("an_slot2", an, 4'b1011);
        goto(47); chk("fd3_pulse", frame_done3, 1'b1); chk("fd4_quiet", frame_done, 1'b0);
        goto(48); chk("fd3_end", frame_done3, 1'b0);
        goto(50); chk("an_slot3", an, 4'b0111);
        goto(63); chk("fd4_pulse", frame_done, 1'b1);
        goto(64); chk("fd4_end", frame_done, 1'b0);

        // Table vectors: load right after reset, observe in frame 1
        for (int i = 0; i < 15; i++) begin
            do_reset(1'b0);
            lz_en = vt[i].lz;
            load_now(vt[i].d, vt[i].p, vt[i].b);
            goto(64 + vt[i].idx * 16 + 5);
            chk($sformatf("vec%0d_sseg", i), sseg, vt[i].s);
            chk($sformatf("vec%0d_an", i), an, vt[i].a);
            chk($sformatf("vec%0d_dp", i), dp, vt[i].dpo);
        end
        lz_en = 1'b0;

        // Mid-frame load is held until the next frame
        do_reset(1'b0);
        load_now(16'h8888, 4'h0, 4'h0);
        goto(83);
        load_now(16'h12AF, 4'b0100, 4'h0);
        goto(117); chk("hold_old_sseg", sseg, 7'h00); chk("hold_old_an", an, 4'b0111);
        goto(133); chk("new_d0_sseg", sseg, 7'h0E);   chk("new_d0_dp", dp, 1'b1);
        goto(165); chk("new_d2_sseg", sseg, 7'h24);   chk("new_d2_dp", dp, 1'b0);
        goto(181); chk("new_d3_sseg", sseg, 7'h79);

        // Load on the wrap edge, then another on the following cycle
        do_reset(1'b0);
        goto(62);
        data = 16'h0005; load = 1'b1;
        @(negedge clk);
        data = 16'h0009;
        @(negedge clk);
        load = 1'b0;
        goto(69);  chk("wrap_first_sseg", sseg, 7'h12);
        goto(133); chk("wrap_second_sseg", sseg, 7'h10);

        // Mid-frame reset discards staged data
        do_reset(1'b0);
        goto(9);
        load_now(16'h1234, 4'h0, 4'h0);
        goto(20);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_an", an, 4'hF);
        chk("midrst_sseg", sseg, 7'h7F);
        reset = 1'b1;
        goto(69); chk("midrst_discard_sseg", sseg, 7'h40); chk("midrst_discard_an", an, 4'b1110);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 799) != 0);
            load  = ($urandom_range(0, 15) == 0);
            data  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) data = data & 16'h00FF;
            dp_in = 4'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
`ifdef SSEG_DIMMING_EN
            if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
`endif
        end
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
